// File: rtl/collision_scanner_pkg.sv
// Shared constants, coordinate type and FSM state encoding for the collision scanner.
// Screen/block geometry defaults and the table dimensions derived from them.
package collision_scanner_pkg;

  localparam int DEF_SCREEN_WIDTH  = 400;
  localparam int DEF_SCREEN_HEIGHT = 700;
  localparam int DEF_BLOCK_WIDTH   = 40;
  localparam int DEF_BLOCK_HEIGHT  = 5;
  localparam int DEF_DOODLE_WIDTH  = 20;

  function automatic int calc_biw(input int screen_w, input int block_w);
    return screen_w / block_w;
  endfunction

  function automatic int calc_bih(input int screen_h, input int block_h);
    return screen_h / block_h;
  endfunction

  localparam int BIW   = calc_biw(DEF_SCREEN_WIDTH, DEF_BLOCK_WIDTH);
  localparam int BIH   = calc_bih(DEF_SCREEN_HEIGHT, DEF_BLOCK_HEIGHT);
  localparam int COUNT = BIW * BIH;

  typedef logic [31:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/collision_scanner_block_hit_compare.sv
// Combinational point-on-block landing test; sums widened to 33 bits so they never wrap.
module block_hit_compare #(
  parameter int BLOCK_WIDTH  = 40,
  parameter int BLOCK_HEIGHT = 5,
  parameter int DOODLE_WIDTH = 20
) (
  input  logic [31:0] point_x,
  input  logic [31:0] point_y,
  input  logic        falling,
  input  logic [31:0] blk_x,
  input  logic [31:0] blk_y,
  input  logic        blk_active,
  output logic        hit
);

  logic [32:0] blk_y_end;
  logic [32:0] blk_x_end;
  logic [32:0] point_x_end;

  always_comb begin
    blk_y_end   = {1'b0, blk_y} + 33'(BLOCK_HEIGHT);
    blk_x_end   = {1'b0, blk_x} + 33'(BLOCK_WIDTH);
    point_x_end = {1'b0, point_x} + 33'(DOODLE_WIDTH);
    hit = blk_active && falling
       && (point_y >= blk_y)
       && ({1'b0, point_y} < blk_y_end)
       && ({1'b0, point_x} < blk_x_end)
       && (point_x_end > {1'b0, blk_x});
  end

endmodule

// File: rtl/collision_scanner.sv
// Walks the block table one entry per cycle and reports the first block the snapshotted
// doodle lands on. Table read port has one cycle of latency: index issued in cycle n, data compared in n+1.
module collision_scanner
  import collision_scanner_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int BLOCK_WIDTH   = DEF_BLOCK_WIDTH,
  parameter int BLOCK_HEIGHT  = DEF_BLOCK_HEIGHT,
  parameter int DOODLE_WIDTH  = DEF_DOODLE_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] doodleX,
  input  logic [31:0] doodleY,
  input  logic        falling,
  output logic [31:0] blkIndex,
  input  logic [31:0] blkX,
  input  logic [31:0] blkY,
  input  logic        blkActive,
  output logic        busy,
  output logic        done,
  output logic        hasCollide,
  output logic [31:0] collisionX,
  output logic [31:0] collisionY
);

  localparam int LBIH   = calc_bih(SCREEN_HEIGHT, BLOCK_HEIGHT);
  localparam int LCOUNT = calc_biw(SCREEN_WIDTH, BLOCK_WIDTH) * LBIH;
  localparam coord_t LAST_IDX = coord_t'(LCOUNT - 1);
  localparam coord_t LAST_J   = coord_t'(LBIH - 1);

  state_t state_q, state_d;
  coord_t snap_x_q, snap_x_d;
  coord_t snap_y_q, snap_y_d;
  logic   snap_fall_q, snap_fall_d;
  // cnt/i/j describe the entry being compared; blk_index runs one entry ahead.
  coord_t cnt_q, cnt_d;
  coord_t i_q, i_d;
  coord_t j_q, j_d;
  coord_t blk_index_q, blk_index_d;
  logic   has_collide_q, has_collide_d;
  coord_t col_x_q, col_x_d;
  coord_t col_y_q, col_y_d;
  logic   hit;

  block_hit_compare #(
    .BLOCK_WIDTH (BLOCK_WIDTH),
    .BLOCK_HEIGHT(BLOCK_HEIGHT),
    .DOODLE_WIDTH(DOODLE_WIDTH)
  ) u_hit (
    .point_x   (snap_x_q),
    .point_y   (snap_y_q),
    .falling   (snap_fall_q),
    .blk_x     (blkX),
    .blk_y     (blkY),
    .blk_active(blkActive),
    .hit       (hit)
  );

  always_comb begin
    state_d       = state_q;
    snap_x_d      = snap_x_q;
    snap_y_d      = snap_y_q;
    snap_fall_d   = snap_fall_q;
    cnt_d         = cnt_q;
    i_d           = i_q;
    j_d           = j_q;
    blk_index_d   = blk_index_q;
    has_collide_d = has_collide_q;
    col_x_d       = col_x_q;
    col_y_d       = col_y_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = ISSUE;
          snap_x_d      = doodleX;
          snap_y_d      = doodleY;
          snap_fall_d   = falling;
          has_collide_d = 1'b0;
          col_x_d       = '0;
          col_y_d       = '0;
          cnt_d         = '0;
          i_d           = '0;
          j_d           = '0;
          blk_index_d   = '0;
        end
      end
      ISSUE: begin
        state_d     = SCAN;
        blk_index_d = (LAST_IDX == '0) ? '0 : 32'd1;
      end
      SCAN: begin
        if (hit) begin
          state_d       = DONE;
          has_collide_d = 1'b1;
          col_x_d       = i_q;
          col_y_d       = j_q;
        end else if (cnt_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (j_q == LAST_J) begin
            j_d = '0;
            i_d = i_q + 32'd1;
          end else begin
            j_d = j_q + 32'd1;
          end
          if (blk_index_q != LAST_IDX) begin
            blk_index_d = blk_index_q + 32'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      snap_x_q      <= '0;
      snap_y_q      <= '0;
      snap_fall_q   <= 1'b0;
      cnt_q         <= '0;
      i_q           <= '0;
      j_q           <= '0;
      blk_index_q   <= '0;
      has_collide_q <= 1'b0;
      col_x_q       <= '0;
      col_y_q       <= '0;
    end else begin
      state_q       <= state_d;
      snap_x_q      <= snap_x_d;
      snap_y_q      <= snap_y_d;
      snap_fall_q   <= snap_fall_d;
      cnt_q         <= cnt_d;
      i_q           <= i_d;
      j_q           <= j_d;
      blk_index_q   <= blk_index_d;
      has_collide_q <= has_collide_d;
      col_x_q       <= col_x_d;
      col_y_q       <= col_y_d;
    end
  end

  assign blkIndex   = blk_index_q;
  assign busy       = (state_q == ISSUE) || (state_q == SCAN);
  assign done       = (state_q == DONE);
  assign hasCollide = has_collide_q;
  assign collisionX = col_x_q;
  assign collisionY = col_y_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner with a one-cycle-latency block table model.
module tb_collision_scanner;

  localparam int TBL = 1400;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] doodleX;
  logic [31:0] doodleY;
  logic        falling;
  logic [31:0] blkIndex;
  logic [31:0] blkX;
  logic [31:0] blkY;
  logic        blkActive;
  logic        busy;
  logic        done;
  logic        hasCollide;
  logic [31:0] collisionX;
  logic [31:0] collisionY;

  logic [31:0] mem_x [TBL];
  logic [31:0] mem_y [TBL];
  logic        mem_a [TBL];

  int n_cmp;
  int n_fail;
  int cyc;

  collision_scanner dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .doodleX   (doodleX),
    .doodleY   (doodleY),
    .falling   (falling),
    .blkIndex  (blkIndex),
    .blkX      (blkX),
    .blkY      (blkY),
    .blkActive (blkActive),
    .busy      (busy),
    .done      (done),
    .hasCollide(hasCollide),
    .collisionX(collisionX),
    .collisionY(collisionY)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block table: registered read, data valid the cycle after the index.
  always @(posedge clk) begin
    if (blkIndex < TBL) begin
      blkX      <= mem_x[blkIndex];
      blkY      <= mem_y[blkIndex];
      blkActive <= mem_a[blkIndex];
    end else begin
      blkX      <= '0;
      blkY      <= '0;
      blkActive <= 1'b0;
    end
  end

  task automatic clear_table();
    for (int k = 0; k < TBL; k++) begin
      mem_x[k] = 32'd0;
      mem_y[k] = 32'd0;
      mem_a[k] = 1'b0;
    end
  endtask

  task automatic set_blk(input int idx, input logic [31:0] x, input logic [31:0] y);
    mem_x[idx] = x;
    mem_y[idx] = y;
    mem_a[idx] = 1'b1;
  endtask

  // Pulse start through one sampling edge; afterwards cyc = 1.
  task automatic start_scan();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
  endtask

  // Waits for done (bounded); optionally disturbs start/doodleY at cycle pc.
  task automatic run_scan(input int pc, output int dcyc, output logic busy_at_done,
                          output logic hc, output logic [31:0] cx, output logic [31:0] cy);
    start_scan();
    while (done !== 1'b1 && cyc < 2000) begin
      if (cyc == pc) begin
        start   = 1'b1;
        doodleY = 32'd500;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    dcyc         = (done === 1'b1) ? cyc : -1;
    busy_at_done = busy;
    hc           = hasCollide;
    cx           = collisionX;
    cy           = collisionY;
  endtask

  task automatic set_doodle(input logic [31:0] x, input logic [31:0] y, input logic f);
    doodleX = x;
    doodleY = y;
    falling = f;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    set_doodle(0, 0, 0);
    clear_table();
    repeat (3) @(posedge clk);
    #1;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_cmp++;
    if (hasCollide !== 1'b0) begin n_fail++; $display("FAIL reset_hc got %0b want 0", hasCollide); end
    n_cmp++;
    if (collisionX !== 32'd0 || collisionY !== 32'd0) begin
      n_fail++; $display("FAIL reset_xy got %0d,%0d want 0,0", collisionX, collisionY);
    end
    n_cmp++;
    if (blkIndex !== 32'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", blkIndex); end
    n_cmp++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Runs a scan and compares done cycle, busy-at-done, flag and indices inline.
  task automatic test_scan(input string name, input int exp_cyc, input logic exp_hc,
                           input logic [31:0] exp_x, input logic [31:0] exp_y, input int pc);
    int dcyc;
    logic bad, hc;
    logic [31:0] cx, cy;
    run_scan(pc, dcyc, bad, hc, cx, cy);
    if (dcyc != exp_cyc) begin n_fail++; $display("FAIL %s done_cycle got %0d want %0d", name, dcyc, exp_cyc); end
    n_cmp++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done got %0b want 0", name, bad); end
    n_cmp++;
    if (hc !== exp_hc) begin n_fail++; $display("FAIL %s hasCollide got %0b want %0b", name, hc, exp_hc); end
    n_cmp++;
    if (cx !== exp_x || cy !== exp_y) begin
      n_fail++; $display("FAIL %s coll got %0d,%0d want %0d,%0d", name, cx, cy, exp_x, exp_y);
    end
    n_cmp++;
    @(posedge clk); #1;
    if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_width got %0b want 0", name, done); end
    n_cmp++;
  endtask

  task automatic test_first_cycle();
    set_doodle(90, 17, 1);
    start_scan();
    if (busy !== 1'b1) begin n_fail++; $display("FAIL cycle1_busy got %0b want 1", busy); end
    n_cmp++;
    if (blkIndex !== 32'd0) begin n_fail++; $display("FAIL cycle1_idx got %0d want 0", blkIndex); end
    n_cmp++;
    while (done !== 1'b1 && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
  endtask

  task automatic test_start_at_done();
    int dcyc;
    logic bad, hc;
    logic [31:0] cx, cy;
    set_doodle(90, 17, 1);
    run_scan(-1, dcyc, bad, hc, cx, cy);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL start_at_done busy got %0b want 0", busy); end
    n_cmp++;
    repeat (3) @(posedge clk);
    #1;
    if (hasCollide !== 1'b1 || collisionX !== 32'd2 || collisionY !== 32'd3) begin
      n_fail++;
      $display("FAIL hold_result got %0b %0d,%0d want 1 2,3", hasCollide, collisionX, collisionY);
    end
    n_cmp++;
    start_scan();
    if (busy !== 1'b1) begin n_fail++; $display("FAIL start_after_done busy got %0b want 1", busy); end
    n_cmp++;
    while (done !== 1'b1 && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_scan();
    int seen_done;
    set_doodle(90, 17, 1);
    start_scan();
    while (cyc < 100) begin @(posedge clk); #1; cyc++; end
    reset = 1'b1;
    #1;
    if (busy !== 1'b0 || done !== 1'b0 || blkIndex !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset got busy=%0b done=%0b idx=%0d want 0 0 0", busy, done, blkIndex);
    end
    n_cmp++;
    @(posedge clk); #1;
    reset = 1'b0;
    seen_done = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done++;
    end
    if (seen_done != 0) begin n_fail++; $display("FAIL mid_reset_done got %0d pulses want 0", seen_done); end
    n_cmp++;
    test_scan("after_reset", 286, 1'b1, 32'd2, 32'd3, -1);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    test_reset();

    test_scan("all_inactive", 1402, 1'b0, 32'd0, 32'd0, -1);

    set_blk(283, 80, 15);
    test_first_cycle();
    set_doodle(90, 17, 1);
    test_scan("hit_283", 286, 1'b1, 32'd2, 32'd3, -1);
    set_doodle(90, 17, 0);
    test_scan("not_falling", 1402, 1'b0, 32'd0, 32'd0, -1);
    set_doodle(120, 17, 1);
    test_scan("x_right_edge", 1402, 1'b0, 32'd0, 32'd0, -1);
    set_doodle(119, 17, 1);
    test_scan("x_right_in", 286, 1'b1, 32'd2, 32'd3, -1);
    set_doodle(60, 17, 1);
    test_scan("x_left_edge", 1402, 1'b0, 32'd0, 32'd0, -1);
    set_doodle(90, 20, 1);
    test_scan("y_bottom_edge", 1402, 1'b0, 32'd0, 32'd0, -1);
    set_doodle(90, 15, 1);
    test_scan("y_top_in", 286, 1'b1, 32'd2, 32'd3, -1);
    set_doodle(90, 17, 1);
    test_scan("mid_scan_inputs", 286, 1'b1, 32'd2, 32'd3, 50);

    test_start_at_done();
    test_reset_mid_scan();

    set_blk(5, 80, 15);
    set_blk(145, 80, 15);
    set_doodle(90, 17, 1);
    test_scan("first_match", 8, 1'b1, 32'd0, 32'd5, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_scanner.md
# collision_scanner

Sequential collision detector sitting directly upstream of the block manager. On each physics tick it snapshots the doodle's feet position and fall state. It then walks the block table one entry per cycle through an indexed read port and reports the first active block the doodle lands on. Results are delivered as `collisionX`, `collisionY` and `hasCollide`, the column/row indices and flag the block manager consumes.

## Interface
- `SCREEN_WIDTH`, 400, screen width in pixels
- `SCREEN_HEIGHT`, 700, screen height in pixels
- `BLOCK_WIDTH`, 40, block width in pixels
- `BLOCK_HEIGHT`, 5, block height in pixels
- `DOODLE_WIDTH`, 20, doodle hitbox width in pixels
- `clk`  in  1  single design clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse that begins a scan
- `doodleX`  in  32  unsigned left pixel of the doodle
- `doodleY`  in  32  unsigned feet pixel of the doodle
- `falling`  in  1  1 = doodle moving downward
- `blkIndex`  out  32  block table read index
- `blkX`, `blkY`  in  32  unsigned; block position at `blkIndex`, registered one cycle after the index
- `blkActive`  in  1  active bit at `blkIndex`, same latency as `blkX`/`blkY`
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle pulse at scan end
- `hasCollide`  out  1  last scan found a landing
- `collisionX`  out  32  column index i of the hit
- `collisionY`  out  32  row index j of the hit

## Operation
- Derived constants:
  - `BIW = SCREEN_WIDTH/BLOCK_WIDTH` (10)
  - `BIH = SCREEN_HEIGHT/BLOCK_HEIGHT` (140)
  - `COUNT = BIW*BIH` (1400)
- Table layout: `index = i*BIH + j`.
- Scan order: index 0..COUNT-1. Row counter j is the fast counter and wraps at BIH-1, at which point i increments. No divider is used; i and j are tracked alongside the index.
- FSM states:
  - IDLE: `start` → ISSUE. Snapshots `doodleX`, `doodleY`, `falling`; clears `hasCollide`, `collisionX`, `collisionY`; sets index, i and j to 0.
  - ISSUE: drives `blkIndex = 0` → SCAN.
  - SCAN: each cycle compares the returned entry against the snapshot, advances the index/i/j, and issues the next index. A hit or the compare of index COUNT-1 → DONE.
  - DONE: pulses `done` for one cycle → IDLE.
- Hit condition, evaluated against the snapshot:
  - `blkActive` = 1, and
  - `falling` = 1, and
  - `blkY ≤ doodleY < blkY + BLOCK_HEIGHT`, and
  - `doodleX < blkX + BLOCK_WIDTH`, and
  - `doodleX + DOODLE_WIDTH > blkX`.
- Arithmetic: all comparisons are 32-bit unsigned. Sums are evaluated in 33 bits so they cannot wrap.
- On a hit: latch i/j of the compared entry into `collisionX`/`collisionY` and set `hasCollide` = 1. The first match (lowest index) wins and the scan terminates early.
- If `falling` = 0 in the snapshot, no block can match and the scan runs the full table, ending with `hasCollide` = 0.
- `start` while `busy` is ignored. Inputs changing mid-scan have no effect because the snapshot is used.
- `hasCollide`, `collisionX` and `collisionY` hold their values until the next accepted `start`.

## Timing
- Reset values: `busy`=0, `done`=0, `hasCollide`=0, `collisionX`=0, `collisionY`=0, `blkIndex`=0; FSM in IDLE.
- `start` sampled at cycle 0:
  - cycle 1: `busy`=1, `blkIndex`=0
  - cycle k+2: data for index k is compared
- Hit at index k: `done` and the valid results appear at cycle k+3. `busy` falls in the same cycle `done` rises.
- No hit: `done` at cycle COUNT+2 (1402).
- `start` coincident with `done` is ignored. A `start` in the cycle after `done` is accepted.
- `reset` asserted mid-scan: immediately returns to IDLE with all outputs at their reset values; no `done` pulse is produced.

## Structure
- Shared package holds: `BIW`, `BIH` and `COUNT` derivation, the 32-bit coordinate typedef, and the FSM state enum (IDLE, ISSUE, SCAN, DONE).
- Natural sub-module: `block_hit_compare`, a purely combinational box/point hit test. It is parameterised on `BLOCK_WIDTH`, `BLOCK_HEIGHT` and `DOODLE_WIDTH` and reusable by the renderer.

## Test plan
- Reset, then pulse `start` with an all-inactive table → `done` at cycle 1402 with `hasCollide`=0 and `collisionX`/`collisionY`=0.
- Block i=2, j=3 (index 283) at X=80, Y=15, active; doodle X=90, Y=17, `falling`=1 → `hasCollide`=1, `collisionX`=2, `collisionY`=3, `done` at cycle 286.
- Same setup with `falling`=0 → full scan ending with `hasCollide`=0.
- Two overlapping active blocks at index 5 and index 145 → reports i=0, j=5. Edge cases:
  - doodle X=120 (exactly `blkX + BLOCK_WIDTH`) → no hit.
  - `doodleY = blkY + 5` → no hit.
- `start` pulsed again mid-scan, and `doodleY` changed mid-scan → neither affects the result or the `done` cycle.
- `reset` asserted at cycle 100 of a scan → `busy`=0 immediately, no `done` pulse; a fresh `start` completes normally.
